// File: rtl/ddr3_axi_bist_if.sv
// AXI4 master port of the DDR3 BIST engine: AW/W/B/AR/R channels toward ddr3_axi.
interface ddr3_axi_bist_if;
  logic        awvalid;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awready;
  logic        wvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        bready;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        rready;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready,
    output arvalid, araddr, arid, arlen, arburst, input arready,
    input rvalid, rdata, rresp, rid, rlast, output rready
  );

  modport slave (
    input awvalid, awaddr, awid, awlen, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready,
    input arvalid, araddr, arid, arlen, arburst, output arready,
    output rvalid, rdata, rresp, rid, rlast, input rready
  );
endinterface

// File: rtl/ddr3_axi_bist.sv
// Memory BIST: writes LFSR pattern over num_bursts INCR bursts, reads it back and counts mismatches.
module ddr3_axi_bist #(
  parameter int          BURST_BEATS = 8,
  parameter logic [31:0] LFSR_POLY   = 32'h80200003
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] num_bursts_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_addr_o,
  ddr3_axi_bist_if.master outport
);
  localparam logic [31:0] STEP      = 32'(BURST_BEATS * 4);
  localparam logic [8:0]  LAST_BEAT = 9'(BURST_BEATS - 1);
  localparam logic [7:0]  LEN       = 8'(BURST_BEATS - 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0] base_q, seed_q, addr_q, lfsr_q, faddr_q;
  logic [15:0] nb_q, idx_q, err_q;
  logic [8:0]  beat_q;
  logic        pass_q, done_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  logic w_fire, beat_last, last_burst, r_err, r_end, err_hit;
  logic [31:0] err_addr;
  logic unused_ids;

  assign unused_ids = ^{outport.bid, outport.rid};
  assign w_fire     = outport.wvalid & outport.wready;
  assign beat_last  = (beat_q == LAST_BEAT);
  assign last_burst = (idx_q + 16'd1 == nb_q);
  // A read beat is bad on data, response or misplaced rlast; any combination counts once.
  assign r_err      = (outport.rdata != lfsr_q) | (outport.rresp != 2'b00) | (outport.rlast != beat_last);
  assign r_end      = outport.rlast | beat_last;
  assign err_hit    = ((state == WR_RESP) & outport.bvalid & (outport.bresp != 2'b00)) |
                      ((state == RD_DATA) & outport.rvalid & r_err);
  assign err_addr   = (state == WR_RESP) ? addr_q : addr_q + 32'({beat_q, 2'b00});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (num_bursts_i == 16'd0) ? DONE : WR_ADDR;
      WR_ADDR: if (outport.awready) state_nxt = WR_DATA;
      WR_DATA: if (w_fire && beat_last) state_nxt = WR_RESP;
      WR_RESP: if (outport.bvalid) state_nxt = last_burst ? RD_ADDR : WR_ADDR;
      RD_ADDR: if (outport.arready) state_nxt = RD_DATA;
      RD_DATA: if (outport.rvalid && r_end) state_nxt = last_burst ? DONE : RD_ADDR;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Payloads are gated by their valid so every output reads 0 while idle or in reset.
  assign outport.awvalid = (state == WR_ADDR);
  assign outport.awaddr  = outport.awvalid ? addr_q : 32'd0;
  assign outport.awid    = 4'h0;
  assign outport.awlen   = outport.awvalid ? LEN : 8'd0;
  assign outport.awburst = outport.awvalid ? 2'b01 : 2'b00;
  assign outport.wvalid  = (state == WR_DATA);
  assign outport.wdata   = outport.wvalid ? lfsr_q : 32'd0;
  assign outport.wstrb   = outport.wvalid ? 4'hF : 4'h0;
  assign outport.wlast   = outport.wvalid & beat_last;
  assign outport.bready  = (state == WR_RESP);
  assign outport.arvalid = (state == RD_ADDR);
  assign outport.araddr  = outport.arvalid ? addr_q : 32'd0;
  assign outport.arid    = 4'h0;
  assign outport.arlen   = outport.arvalid ? LEN : 8'd0;
  assign outport.arburst = outport.arvalid ? 2'b01 : 2'b00;
  assign outport.rready  = (state == RD_DATA);

  assign busy_o           = (state != IDLE);
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = faddr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q <= '0; seed_q <= '0; addr_q <= '0; lfsr_q <= '0; faddr_q <= '0;
      nb_q <= '0; idx_q <= '0; err_q <= '0; beat_q <= '0; pass_q <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      if (err_hit) begin
        if (err_q == 16'd0) faddr_q <= err_addr;
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      end
      case (state)
        IDLE: if (start_i) begin
          base_q  <= {base_addr_i[31:2], 2'b00};
          addr_q  <= {base_addr_i[31:2], 2'b00};
          seed_q  <= (seed_i == 32'd0) ? 32'd1 : seed_i;
          lfsr_q  <= (seed_i == 32'd0) ? 32'd1 : seed_i;
          nb_q    <= num_bursts_i;
          idx_q   <= '0;
          beat_q  <= '0;
          err_q   <= '0;
          faddr_q <= '0;
          pass_q  <= 1'b0;
        end
        WR_DATA: if (w_fire) begin
          lfsr_q <= lfsr_step(lfsr_q);
          beat_q <= beat_last ? 9'd0 : beat_q + 9'd1;
        end
        WR_RESP: if (outport.bvalid) begin
          // Read phase replays the same sequence from the seed over the same bursts.
          if (last_burst) begin
            idx_q <= '0; addr_q <= base_q; lfsr_q <= seed_q;
          end else begin
            idx_q <= idx_q + 16'd1; addr_q <= addr_q + STEP;
          end
        end
        RD_DATA: if (outport.rvalid) begin
          lfsr_q <= lfsr_step(lfsr_q);
          if (r_end) begin
            beat_q <= '0;
            if (!last_burst) begin
              idx_q <= idx_q + 16'd1; addr_q <= addr_q + STEP;
            end
          end else begin
            beat_q <= beat_q + 9'd1;
          end
        end
        DONE: pass_q <= (err_q == 16'd0);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_axi_bist.sv
// Scoreboard bench: AXI memory slave with fault injection, reference model predicts writes and results.
module tb_ddr3_axi_bist;
  localparam int          BB   = 8;
  localparam logic [31:0] POLY = 32'h80200003;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] base = '0, seed = '0;
  logic [15:0] nb = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] faddr;

  ddr3_axi_bist_if bus();

  ddr3_axi_bist #(.BURST_BEATS(BB), .LFSR_POLY(POLY)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base), .num_bursts_i(nb),
    .seed_i(seed), .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .first_err_addr_o(faddr), .outport(bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] addr; logic [31:0] data; logic last;} wbeat_t;
  typedef struct {logic [15:0] cnt; logic [31:0] faddr; logic pass;} res_t;
  wbeat_t      exp_w[$];
  res_t        exp_res[$];
  logic [31:0] aw_log[$];

  // slave configuration and state
  int          aw_stall = 0, flip_g = -1, rresp_g = -1, nolast_g = -1, rdy_pct = 100;
  bit [15:0]   bad_b_mask = '0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr = '0, rd_addr = '0;
  int          wbeat = 0, rbeat = 0, bidx = 0, rg = 0;
  bit          b_pend = 0, r_act = 0;
  int          vcyc = 0, stall_seen = 0, wcnt = 0, dseen = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
  endfunction

  function automatic bit rnd();
    return $urandom_range(99) < rdy_pct;
  endfunction

  // Reference: bursts are contiguous, so read beat g of the run sits at base + 4*g.
  task automatic model(input logic [31:0] b0, input int n, input logic [31:0] s0);
    logic [31:0] b = {b0[31:2], 2'b00};
    logic [31:0] l = (s0 == 0) ? 32'd1 : s0;
    res_t r = '{cnt: 16'd0, faddr: 32'd0, pass: 1'b0};
    for (int i = 0; i < n; i++)
      for (int k = 0; k < BB; k++) begin
        exp_w.push_back('{addr: b + 32'((i * BB + k) * 4), data: l, last: (k == BB - 1)});
        l = lfsr_next(l);
      end
    for (int i = 0; i < n; i++)
      if (bad_b_mask[i]) begin
        if (r.cnt == 0) r.faddr = b + 32'(i * BB * 4);
        r.cnt++;
      end
    for (int g = 0; g < n * BB; g++)
      if (g == flip_g || g == rresp_g || g == nolast_g) begin
        if (r.cnt == 0) r.faddr = b + 32'(g * 4);
        r.cnt++;
      end
    r.pass = (r.cnt == 0);
    exp_res.push_back(r);
  endtask

  // AXI memory slave: handshakes are sampled at negedge, responses driven #1 after posedge.
  initial begin
    logic aw_f, w_f, w_l, b_f, ar_f, r_f;
    logic [31:0] aw_a, w_d, ar_a, a;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rid = 0; bus.rlast = 0;
    forever begin
      @(negedge clk);
      aw_f = bus.awvalid && bus.awready; aw_a = bus.awaddr;
      w_f  = bus.wvalid && bus.wready;   w_d = bus.wdata; w_l = bus.wlast;
      b_f  = bus.bvalid && bus.bready;
      ar_f = bus.arvalid && bus.arready; ar_a = bus.araddr;
      r_f  = bus.rvalid && bus.rready;
      @(posedge clk); #1;
      if (rst) begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
        b_pend = 0; r_act = 0; wbeat = 0; rbeat = 0; aw_stall = 0;
        continue;
      end
      if (aw_f) begin wr_addr = aw_a; wbeat = 0; end
      if (w_f) begin
        mem[wr_addr + 32'(wbeat * 4)] = w_d; wbeat++;
        if (w_l) b_pend = 1;
      end
      if (b_f) begin bus.bvalid = 0; bidx++; end
      if (ar_f) begin rd_addr = ar_a; rbeat = 0; r_act = 1; end
      if (r_f) begin
        bus.rvalid = 0; rbeat++; rg++;
        if (rbeat == BB) r_act = 0;
      end
      if (bus.awvalid && aw_stall > 0) begin aw_stall--; bus.awready = 0; end
      else bus.awready = bus.awvalid && rnd();
      bus.wready  = bus.wvalid && rnd();
      bus.arready = bus.arvalid && rnd();
      if (b_pend && !bus.bvalid && rnd()) begin
        bus.bvalid = 1; bus.bresp = bad_b_mask[bidx] ? 2'b10 : 2'b00; b_pend = 0;
      end
      if (r_act && !bus.rvalid && rnd()) begin
        a = rd_addr + 32'(rbeat * 4);
        bus.rdata = mem.exists(a) ? mem[a] : 32'hDEADBEEF;
        if (rg == flip_g) bus.rdata = bus.rdata ^ 32'd1;
        bus.rresp = (rg == rresp_g) ? 2'b10 : 2'b00;
        bus.rlast = (rbeat == BB - 1) && (rg != nolast_g);
        bus.rvalid = 1;
      end
    end
  end

  // Monitor: pops expected writes and results, checks handshake stability.
  initial begin
    bit aw_hold = 0, w_hold = 0;
    logic [31:0] aw_prev = '0, w_prev = '0;
    wbeat_t e;
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin aw_hold = 0; w_hold = 0; continue; end
      if (bus.awvalid || bus.wvalid || bus.arvalid) vcyc++;
      if (bus.awvalid && !bus.awready) stall_seen++;
      if (aw_hold) begin
        check("aw_hold_valid", bus.awvalid, 1);
        check("aw_hold_addr", bus.awaddr, aw_prev);
      end
      if (w_hold) begin
        check("w_hold_valid", bus.wvalid, 1);
        check("w_hold_data", bus.wdata, w_prev);
      end
      aw_hold = bus.awvalid && !bus.awready; aw_prev = bus.awaddr;
      w_hold  = bus.wvalid && !bus.wready;   w_prev  = bus.wdata;
      if (bus.awvalid && bus.awready) begin
        aw_log.push_back(bus.awaddr);
        check("awlen", bus.awlen, BB - 1);
        check("awburst", bus.awburst, 2'b01);
      end
      if (bus.wvalid && bus.wready) begin
        wcnt++;
        if (exp_w.size() == 0) check("w_unexpected", 1, 0);
        else begin
          e = exp_w.pop_front();
          check("w_addr", wr_addr + 32'(wbeat * 4), e.addr);
          check("wdata", bus.wdata, e.data);
          check("wlast", bus.wlast, e.last);
          check("wstrb", bus.wstrb, 4'hF);
        end
      end
      if (done) begin
        dseen++;
        if (exp_res.size() == 0) check("done_unexpected", 1, 0);
        else begin
          r = exp_res.pop_front();
          check("err_count", err_count, r.cnt);
          check("first_err_addr", faddr, r.faddr);
          check("pass", pass, r.pass);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic kick(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    model(b, int'(n), s);
    bidx = 0; rg = 0; vcyc = 0; stall_seen = 0; wcnt = 0; aw_log.delete();
    @(posedge clk); #1;
    base = b; nb = n; seed = s; start = 1;
    @(posedge clk); #1;
    start = 0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s, output int cyc);
    int d0;
    d0 = dseen;
    kick(b, n, s);
    cyc = 0;
    while (dseen == d0 && cyc < 20000) begin @(posedge clk); cyc++; end
    if (dseen == d0) begin
      check("done_timeout", 0, 1);
      exp_res.delete();
    end
    check("w_queue_drained", exp_w.size(), 0);
    exp_w.delete();
  endtask

  task automatic clear_cfg();
    flip_g = -1; rresp_g = -1; nolast_g = -1; bad_b_mask = '0; rdy_pct = 100; aw_stall = 0;
  endtask

  initial begin
    int c, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err_addr", faddr, 0);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
    check("rst_readies", {bus.bready, bus.rready}, 0);
    check("rst_awaddr_awlen", {bus.awaddr, bus.awlen}, 0);
    rst = 0;

    clear_cfg();
    run(32'h80, 16'd1, 32'd1, c);

    flip_g = 3;
    run(32'h80, 16'd1, 32'd1, c);
    clear_cfg();

    run(32'h1000, 16'd0, 32'd5, c);
    check("nb0_done_latency", c, 2);
    check("nb0_no_valid", vcyc, 0);

    aw_stall = 5; bad_b_mask = 16'h1;
    run(32'h200, 16'd1, 32'h1234, c);
    check("aw_stall_cycles", stall_seen, 5);
    clear_cfg();

    // abort mid write burst, then a clean run
    kick(32'h400, 16'd2, 32'hABCD);
    c = 0;
    while (wcnt < 4 && c < 1000) begin @(posedge clk); c++; end
    check("reach_beat4", wcnt, 4);
    #2 rst = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check("abort_wdata", bus.wdata, 0);
    check("abort_status", {done, pass, err_count, faddr}, 0);
    exp_w.delete(); exp_res.delete();
    @(posedge clk); @(posedge clk); #3 rst = 0;
    run(32'h400, 16'd2, 32'hABCD, c);

    run(32'hFFFFFFE0, 16'd2, 32'h77, c);
    check("wrap_aw_count", aw_log.size(), 2);
    if (aw_log.size() == 2) check("wrap_second_addr", aw_log[1], 32'h0);

    nolast_g = BB - 1;
    run(32'h600, 16'd1, 32'h9, c);
    clear_cfg();

    flip_g = 5; rresp_g = 5;
    run(32'h703, 16'd2, 32'h0, c);
    clear_cfg();

    for (int t = 0; t < 12; t++) begin
      rdy_pct = 60;
      n = $urandom_range(1, 4);
      bad_b_mask = 16'($urandom) & 16'((1 << n) - 1);
      flip_g  = ($urandom_range(1) == 1) ? int'($urandom_range(n * BB - 1)) : -1;
      rresp_g = ($urandom_range(2) == 0) ? int'($urandom_range(n * BB - 1)) : -1;
      run($urandom, 16'(n), ($urandom_range(3) == 0) ? 32'd0 : $urandom, c);
      clear_cfg();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
